// File: rtl/z80_screen_write_capture.sv
// Z80 screen-write snooper: watches the asynchronous Z80 bus from the clk25
// domain and queues memory writes that land in the display file and attribute
// area. Queued writes are offered on a valid/ready port to the SDRAM write path.
//
// Optional build macro BORDER_PORT_EN adds a second strobe FSM on IORQ|WR that
// tracks ULA port 0xFE writes and drives a 3-bit border colour output.
//
// Strobe FSM (one instance for memory writes, one for I/O writes when enabled):
//   state       | meaning
//   S_WAIT_HIGH | waiting for the synchronised strobe to be seen high
//   S_ARMED     | strobe idle high, ready for a falling edge
//   S_LOW1      | strobe seen low once; second low sample issues the event
module z80_screen_write_capture #(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] SCREEN_BASE = 16'h4000,
  parameter logic [15:0] SCREEN_TOP  = 16'h5AFF
) (
  input  logic                          clk25,
  input  logic                          RESET,
  input  logic [15:0]                   A,
  input  logic [7:0]                    D,
  input  logic                          MREQ,
  input  logic                          WR,
  input  logic                          IORQ,
  output logic                          wr_valid,
  input  logic                          wr_ready,
  output logic [12:0]                   wr_addr,
  output logic [7:0]                    wr_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
`ifdef BORDER_PORT_EN
  ,
  output logic [2:0]                    border
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_WAIT_HIGH,
    S_ARMED,
    S_LOW1
  } strobe_state_e;

  // The sync flops reset to 1, so during the first two cycles after reset
  // their output is the reset value rather than the pin. The settle flag keeps
  // S_WAIT_HIGH from trusting that stale high, so a strobe held low across
  // reset release cannot produce an event.
  function automatic strobe_state_e strobe_next(input strobe_state_e cur,
                                                input logic strobe_s,
                                                input logic settled);
    strobe_state_e nxt;
    nxt = S_WAIT_HIGH;
    case (cur)
      S_WAIT_HIGH: nxt = (strobe_s && settled) ? S_ARMED : S_WAIT_HIGH;
      S_ARMED:     nxt = strobe_s ? S_ARMED : S_LOW1;
      S_LOW1:      nxt = strobe_s ? S_ARMED : S_WAIT_HIGH;
      default:     nxt = S_WAIT_HIGH;
    endcase
    return nxt;
  endfunction

  logic          ms_meta, ms_s;
  logic [1:0]    settle_q;
  logic          settled;
  strobe_state_e mem_state_q, mem_state_d;
  logic          mem_event;

  logic          in_range, push_req, push_acc, push_drop, pop, full;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [20:0]   fifo_mem [FIFO_DEPTH];
  logic [20:0]   head;

  assign settled = settle_q[1];

  // Two-flop synchroniser for the memory-write strobe, plus post-reset settle flag.
  always_ff @(posedge clk25 or negedge RESET) begin
    if (!RESET) begin
      ms_meta  <= 1'b1;
      ms_s     <= 1'b1;
      settle_q <= 2'b00;
    end else begin
      ms_meta  <= MREQ | WR;
      ms_s     <= ms_meta;
      settle_q <= {settle_q[0], 1'b1};
    end
  end

  // Memory strobe FSM state register.
  always_ff @(posedge clk25 or negedge RESET) begin
    if (!RESET) mem_state_q <= S_WAIT_HIGH;
    else        mem_state_q <= mem_state_d;
  end

  // Memory strobe FSM next state and event decode.
  always_comb begin
    mem_state_d = strobe_next(mem_state_q, ms_s, settled);
    mem_event   = (mem_state_q == S_LOW1) && !ms_s;
  end

  // Push/pop decode; a full FIFO still accepts a push when the head pops the same cycle.
  always_comb begin
    in_range  = (A >= SCREEN_BASE) && (A <= SCREEN_TOP);
    push_req  = mem_event && in_range;
    full      = (fifo_level == CW'(FIFO_DEPTH));
    pop       = wr_valid && wr_ready;
    push_acc  = push_req && (!full || pop);
    push_drop = push_req && full && !pop;
  end

  // FIFO storage; A and D are taken straight from the pins on the event edge.
  always_ff @(posedge clk25) begin
    if (push_acc) fifo_mem[wr_ptr] <= {A[12:0] - SCREEN_BASE[12:0], D};
  end

  // FIFO pointers, level and sticky overflow.
  always_ff @(posedge clk25 or negedge RESET) begin
    if (!RESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_acc)  wr_ptr <= wr_ptr + PW'(1);
      if (pop)       rd_ptr <= rd_ptr + PW'(1);
      fifo_level <= fifo_level + CW'(push_acc) - CW'(pop);
      if (push_drop) overflow <= 1'b1;
    end
  end

  // First-word-fall-through head, forced to zero when empty.
  always_comb begin
    head     = fifo_mem[rd_ptr];
    wr_valid = (fifo_level != '0);
    wr_addr  = wr_valid ? head[20:8] : '0;
    wr_data  = wr_valid ? head[7:0]  : '0;
  end

`ifdef BORDER_PORT_EN
  logic          io_meta, io_s;
  strobe_state_e io_state_q, io_state_d;
  logic          io_event;

  // Two-flop synchroniser for the I/O-write strobe.
  always_ff @(posedge clk25 or negedge RESET) begin
    if (!RESET) begin
      io_meta <= 1'b1;
      io_s    <= 1'b1;
    end else begin
      io_meta <= IORQ | WR;
      io_s    <= io_meta;
    end
  end

  // I/O strobe FSM state register.
  always_ff @(posedge clk25 or negedge RESET) begin
    if (!RESET) io_state_q <= S_WAIT_HIGH;
    else        io_state_q <= io_state_d;
  end

  // I/O strobe FSM next state and event decode.
  always_comb begin
    io_state_d = strobe_next(io_state_q, io_s, settled);
    io_event   = (io_state_q == S_LOW1) && !io_s;
  end

  // Border colour latch for ULA port writes (A[0] low).
  always_ff @(posedge clk25 or negedge RESET) begin
    if (!RESET)                 border <= 3'b000;
    else if (io_event && !A[0]) border <= D[2:0];
  end
`else
  logic unused_iorq;
  assign unused_iorq = IORQ;
`endif

endmodule

// File: doc/z80_screen_write_capture.md
Name: z80_screen_write_capture

Overview:
- Upstream feeder for vga_mem: snoops the asynchronous Z80 bus in the clk25 domain.
- Detects memory write cycles that fall inside the Spectrum display file and attribute area (0x4000–0x5AFF).
- Queues each detected write as an address/data pair in a small FIFO.
- Presents queued writes on a valid/ready port; vga_mem's SDRAM write path drains that port.

Parameters:
- FIFO_DEPTH, 8, number of queued writes; must be a power of 2, minimum 2.
- SCREEN_BASE, 16'h4000, lowest captured Z80 address (inclusive).
- SCREEN_TOP, 16'h5AFF, highest captured Z80 address (inclusive).

Ports:
- clk25  input  1  system clock, 25 MHz.
- RESET  input  1  asynchronous, active-low reset.
- A  input  16  Z80 address bus; asynchronous to clk25.
- D  input  8  Z80 data bus; asynchronous to clk25.
- MREQ  input  1  Z80 memory request, active-low.
- WR  input  1  Z80 write strobe, active-low.
- IORQ  input  1  Z80 I/O request, active-low.
- wr_valid  output  1  FIFO head holds a write.
- wr_ready  input  1  consumer accepts the head this cycle.
- wr_addr  output  13  head address minus SCREEN_BASE.
- wr_data  output  8  head data byte.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current entry count.
- overflow  output  1  sticky flag: a write was dropped.

Behaviour:
- Reset (RESET low, asynchronous): FIFO emptied; wr_valid=0; wr_addr=0; wr_data=0; fifo_level=0; overflow=0; sync flops set to 1; FSM enters S_WAIT_HIGH.
- Synchroniser: mem strobe ms = MREQ | WR, passed through 2 flops giving ms_s. IORQ is synchronised the same way giving io_s. A and D are not synchronised.
- FSM (one event per bus write):
  - S_WAIT_HIGH: ms_s=1 -> S_ARMED.
  - S_ARMED: ms_s=0 -> S_LOW1.
  - S_LOW1: ms_s=0 -> issue event, go to S_WAIT_HIGH; ms_s=1 -> S_ARMED (glitch rejected).
- Event: A and D are sampled directly from the pins on the event edge. The bus has been stable for at least 3 cycles by then.
- Address filter: the event is accepted only if SCREEN_BASE <= A <= SCREEN_TOP. Out-of-range events are discarded silently and do not affect overflow.
- Latency: counting the first clk25 edge that registers ms low as edge 1, the push occurs at edge 4 and wr_valid is high after edge 4.
- A strobe already low when reset releases produces no event, because the FSM must first see ms_s=1.
- FIFO behaviour:
  - First-word-fall-through: wr_addr and wr_data always show the head entry, and show 0 when empty.
  - wr_valid = (fifo_level != 0).
  - Pop occurs when wr_valid && wr_ready; head advances on that edge.
  - Push and pop in the same cycle: both take effect; fifo_level is unchanged.
  - Full, push without pop: the write is dropped, overflow is set to 1, and FIFO contents are untouched.
  - Full, push with simultaneous pop: the push is accepted and nothing is dropped.
  - Pointers wrap modulo FIFO_DEPTH. fifo_level ranges from 0 to FIFO_DEPTH.
- overflow is cleared only by RESET.
- wr_ready while empty has no effect.

Optional Feature:
- Macro: BORDER_PORT_EN.
- When defined:
  - Adds an output border (3 bits) with reset value 3'b000.
  - Adds a parallel FSM on (IORQ | WR), synchronised as io_s, with identical states and timing.
  - On its event, if A[0]=0 (ULA port 0xFE), border <= D[2:0].
  - Independent of the FIFO; never causes overflow.
- When undefined: the border port, the IORQ synchroniser and the I/O FSM are absent. IORQ is unused.

Test Plan:
- Reset, then a single memory write A=0x4000, D=0xA5, strobe low 10 cycles -> wr_valid high after edge 4; wr_addr=0x0000, wr_data=0xA5, fifo_level=1. With wr_ready=1 for one cycle -> wr_valid=0, fifo_level=0.
- Out-of-range writes at A=0x3FFF and A=0x5B00, plus an in-range write at A=0x5AFF, D=0x3C -> exactly one entry: wr_addr=0x1AFF, wr_data=0x3C.
- wr_ready=0 with 9 in-range writes, D=1..9 -> fifo_level=8, overflow=1. Draining yields data 1..8 in order; entry 9 is absent.
- FIFO full, wr_ready=1 held during a 9th write -> no drop; overflow stays 0; output sequence is continuous.
- 1-cycle low glitch on MREQ|WR -> no entry. RESET asserted while the strobe is low and released while it is still low -> no entry until the strobe goes high and then low again.
- BORDER_PORT_EN defined: I/O write A=0x00FE, D=0x05 -> border=3'b101 after edge 4, fifo_level stays 0. I/O write A=0x00FF -> border unchanged.
